key_edge_debouncer: RTL and testbench

//  Debounces one raw mechanical key input and produces a clean level plus single-cycle

---
 rtl/key_edge_debouncer.sv | 98 +++++++++
 tb/tb_key_edge_debouncer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_edge_debouncer.sv
// Key debouncer: two-flop synchronizer feeding a four-state stability FSM that
// produces a clean pressed level plus one-cycle press/release pulses.
module key_edge_debouncer #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 15,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_rise,
  output logic key_fall
);

  localparam int N  = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic RELEASED = ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          pressed;
  state_t        state_reg;
  logic [CW-1:0] cnt_reg;

  // Sync flops reset to the idle pin level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= RELEASED;
      sync2_reg <= RELEASED;
    end else begin
      sync1_reg <= key_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign pressed = ACTIVE_LOW ? ~sync2_reg : sync2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      key_level <= 1'b0;
      key_rise  <= 1'b0;
      key_fall  <= 1'b0;
    end else begin
      key_rise <= 1'b0;
      key_fall <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pressed) begin
            state_reg <= PRESS_WAIT;
            cnt_reg   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed) begin
            state_reg <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= PRESSED;
            key_level <= 1'b1;
            key_rise  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        PRESSED: begin
          if (!pressed) begin
            state_reg <= RELEASE_WAIT;
            cnt_reg   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A short return to pressed is a glitch: level stays high, no new rise.
          if (pressed) begin
            state_reg <= PRESSED;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= IDLE;
            key_level <= 1'b0;
            key_fall  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_edge_debouncer.sv
// Bench for key_edge_debouncer: an active-low and an active-high instance (N = 4)
// checked every cycle against a run-length model, plus directed latency checks.
module tb_key_edge_debouncer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key [2];
  logic lvl_o [2];
  logic rise_o [2];
  logic fall_o [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_edge_debouncer #(.CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .ACTIVE_LOW(1'b1)) dut_low (
    .clk(clk), .rst(rst), .key_in(key[0]),
    .key_level(lvl_o[0]), .key_rise(rise_o[0]), .key_fall(fall_o[0])
  );

  key_edge_debouncer #(.CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .ACTIVE_LOW(1'b0)) dut_high (
    .clk(clk), .rst(rst), .key_in(key[1]),
    .key_level(lvl_o[1]), .key_rise(rise_o[1]), .key_fall(fall_o[1])
  );

  // Two-digit BCD press counter fed by the active-high instance.
  logic [7:0] bcd;
  always @(posedge clk or posedge rst) begin
    if (rst) bcd <= 8'h00;
    else if (rise_o[1]) begin
      if (bcd[3:0] == 4'd9) bcd <= {bcd[7:4] + 4'd1, 4'd0};
      else bcd <= bcd + 8'd1;
    end
  end

  // Model: pin sample seen two edges late; the level flips once N+1 consecutive
  // samples disagree with it, emitting a one-cycle pulse on that edge.
  logic m1 [2];
  logic m2 [2];
  logic mlvl [2];
  logic er [2];
  logic ef [2];
  int   run [2];

  function automatic logic pressed_of(int i, logic s);
    return (i == 0) ? ~s : s;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m1[i]   <= (i == 0);
        m2[i]   <= (i == 0);
        mlvl[i] <= 1'b0;
        er[i]   <= 1'b0;
        ef[i]   <= 1'b0;
        run[i]  <= 0;
      end else begin
        m1[i] <= key[i];
        m2[i] <= m1[i];
        er[i] <= 1'b0;
        ef[i] <= 1'b0;
        if (pressed_of(i, m2[i]) == mlvl[i]) begin
          run[i] <= 0;
        end else if (run[i] == N) begin
          mlvl[i] <= ~mlvl[i];
          er[i]   <= ~mlvl[i];
          ef[i]   <= mlvl[i];
          run[i]  <= 0;
        end else begin
          run[i] <= run[i] + 1;
        end
      end
    end
  end

  int rise_cnt [2];
  int fall_cnt [2];
  int last_rise [2];
  int last_fall [2];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      rise_cnt[i] = 0; fall_cnt[i] = 0; last_rise[i] = -1; last_fall[i] = -1;
    end
  endtask

  // Every cycle: compare both instances with the model at the falling edge.
  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("level%0d", i), int'(lvl_o[i]), int'(mlvl[i]));
        chk($sformatf("rise%0d", i), int'(rise_o[i]), int'(er[i]));
        chk($sformatf("fall%0d", i), int'(fall_o[i]), int'(ef[i]));
        if (rise_o[i] === 1'b1) begin rise_cnt[i]++; last_rise[i] = cyc; end
        if (fall_o[i] === 1'b1) begin fall_cnt[i]++; last_fall[i] = cyc; end
      end
      #1;
    end
  endtask

  int e0;

  initial begin
    key[0] = 1'b0;
    key[1] = 1'b0;
    clear_counts();

    // 1: reset held with key pressed, then full debounce after release of rst
    tick(3);
    chk("rst_level", int'(lvl_o[0]), 0);
    chk("rst_rise", int'(rise_o[0]), 0);
    chk("rst_fall", int'(fall_o[0]), 0);
    rst = 1'b0;
    clear_counts();
    e0 = cyc + 1;
    tick(15);
    $display("txn 1: reset-held press rise_cnt=%0d at cycle %0d", rise_cnt[0], last_rise[0]);
    chk("s1_rise_count", rise_cnt[0], 1);
    chk("s1_rise_edge", last_rise[0], e0 + 6);

    // 2: clean press held 20 cycles
    key[0] = 1'b1;
    tick(15);
    clear_counts();
    e0 = cyc + 1;
    key[0] = 1'b0;
    tick(20);
    $display("txn 2: clean press rise_cnt=%0d at cycle %0d", rise_cnt[0], last_rise[0]);
    chk("s2_rise_count", rise_cnt[0], 1);
    chk("s2_rise_edge", last_rise[0], e0 + 6);
    chk("s2_fall_count", fall_cnt[0], 0);
    chk("s2_level", int'(lvl_o[0]), 1);

    // 3: bouncing press, toggling every 2 cycles
    key[0] = 1'b1;
    tick(15);
    clear_counts();
    for (int j = 0; j < 12; j++) begin
      key[0] = ((j / 2) % 2 == 1);
      tick(1);
    end
    e0 = cyc + 1;
    key[0] = 1'b0;
    tick(15);
    $display("txn 3: bounced press rise_cnt=%0d at cycle %0d", rise_cnt[0], last_rise[0]);
    chk("s3_rise_count", rise_cnt[0], 1);
    chk("s3_rise_edge", last_rise[0], e0 + 6);

    // 4: 3-cycle release glitch while pressed, then a real release
    clear_counts();
    key[0] = 1'b1;
    tick(3);
    key[0] = 1'b0;
    tick(15);
    $display("txn 4a: glitch rise_cnt=%0d fall_cnt=%0d", rise_cnt[0], fall_cnt[0]);
    chk("s4_glitch_fall", fall_cnt[0], 0);
    chk("s4_glitch_rise", rise_cnt[0], 0);
    chk("s4_glitch_level", int'(lvl_o[0]), 1);
    clear_counts();
    e0 = cyc + 1;
    key[0] = 1'b1;
    tick(15);
    $display("txn 4b: release fall_cnt=%0d at cycle %0d", fall_cnt[0], last_fall[0]);
    chk("s4_fall_count", fall_cnt[0], 1);
    chk("s4_fall_edge", last_fall[0], e0 + 6);
    chk("s4_level", int'(lvl_o[0]), 0);

    // 5: reset asserted in the middle of a press debounce
    clear_counts();
    key[0] = 1'b0;
    tick(4);
    rst = 1'b1;
    #1;
    chk("s5_rst_level", int'(lvl_o[0]), 0);
    chk("s5_rst_rise", int'(rise_o[0]), 0);
    chk("s5_rst_fall", int'(fall_o[0]), 0);
    tick(2);
    chk("s5_no_rise_before_rst", rise_cnt[0], 0);
    rst = 1'b0;
    e0 = cyc + 1;
    tick(15);
    $display("txn 5: press after mid-debounce reset rise_cnt=%0d at cycle %0d", rise_cnt[0], last_rise[0]);
    chk("s5_rise_count", rise_cnt[0], 1);
    chk("s5_rise_edge", last_rise[0], e0 + 6);

    // 6: ten clean presses on the active-high instance into the BCD counter
    key[0] = 1'b1;
    tick(15);
    clear_counts();
    for (int p = 0; p < 10; p++) begin
      key[1] = 1'b1;
      tick(10);
      key[1] = 1'b0;
      tick(10);
    end
    tick(10);
    $display("txn 6: active-high rises=%0d falls=%0d bcd=%02h", rise_cnt[1], fall_cnt[1], bcd);
    chk("s6_rise_count", rise_cnt[1], 10);
    chk("s6_fall_count", fall_cnt[1], 10);
    chk("s6_bcd", int'(bcd), 'h10);
    chk("s6_other_quiet", rise_cnt[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
